// File: rtl/ram_sp_be_init_if.sv
// Access bus for ram_sp_be_init: request/write-data from the client, read data and status back.
interface ram_sp_be_init_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic            en;
  logic            we;
  logic [DW/8-1:0] be;
  logic [AW-1:0]   ADDR;
  logic [DW-1:0]   Din;
  logic            clr;
  logic [DW-1:0]   Dout;
  logic            dvalid;
  logic            err;
  logic            busy;

  modport master (
    output en, we, be, ADDR, Din, clr,
    input  Dout, dvalid, err, busy
  );

  modport slave (
    input  en, we, be, ADDR, Din, clr,
    output Dout, dvalid, err, busy
  );
endinterface

// File: rtl/ram_sp_be_init.sv
// Single-port RAM with byte-lane writes, 1- or 2-cycle read latency, write-mode select,
// out-of-range flagging and a clear engine that fills every word with INIT_VAL.
module ram_sp_be_init #(
  parameter int            DW       = 32,
  parameter int            AW       = 10,
  parameter int            DEPTH    = 1024,
  parameter int            RD_LAT   = 1,
  parameter int            WR_MODE  = 0,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input logic               clk,
  input logic               rst,
  ram_sp_be_init_if.slave   bus
);

  localparam int            NB      = DW / 8;
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic          LAT2    = (RD_LAT == 2);
  localparam logic          WR_RET  = (WR_MODE == 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_busy, w_acc, w_oor, w_wr_ok;
  logic [DW-1:0]   w_word_p1;

  logic [DW-1:0]   r_rd_p1, r_din_p1;
  logic [NB-1:0]   r_be_p1;
  logic            r_vld_p1, r_err_p1;
  logic            r_vld_p2, r_err_p2;
  logic [DW-1:0]   r_dout_p2;

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [NB-1:0] lanes);
    logic [DW-1:0] m;
    m = old_w;
    for (int i = 0; i < NB; i++)
      if (lanes[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

  assign w_busy  = (r_state == S_CLEAR);
  // clr in the same cycle as a request wins; the request is dropped
  assign w_acc   = bus.en & ~w_busy & ~bus.clr;
  assign w_oor   = ({1'b0, bus.ADDR} >= DEPTH_W);
  assign w_wr_ok = w_acc & bus.we & ~w_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      S_IDLE: begin
        if (bus.clr) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // ---- stage p0 -> p1: array access (read-before-write) and request capture ----
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= INIT_VAL;
    end else if (w_wr_ok) begin
      for (int i = 0; i < NB; i++)
        if (bus.be[i]) r_mem[bus.ADDR][8*i +: 8] <= bus.Din[8*i +: 8];
    end
    r_rd_p1  <= r_mem[bus.ADDR];
    r_din_p1 <= bus.Din;
    r_be_p1  <= bus.be & {NB{bus.we}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_err_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_err_p2  <= 1'b0;
      r_dout_p2 <= '0;
    end else begin
      r_vld_p1 <= w_acc & (~bus.we | (WR_RET & ~w_oor));
      r_err_p1 <= w_acc & w_oor;
      // ---- stage p1 -> p2: merged word retained as the held output ----
      r_vld_p2 <= r_vld_p1;
      r_err_p2 <= r_err_p1;
      if (r_vld_p1) r_dout_p2 <= w_word_p1;
    end
  end

  // Old word from the array merged with the write lanes gives the write-first result
  assign w_word_p1  = r_err_p1 ? '0 : merge_lanes(r_rd_p1, r_din_p1, r_be_p1);

  assign bus.Dout   = (LAT2 || !r_vld_p1) ? r_dout_p2 : w_word_p1;
  assign bus.dvalid = LAT2 ? r_vld_p2 : r_vld_p1;
  assign bus.err    = LAT2 ? r_err_p2 : r_err_p1;
  assign bus.busy   = w_busy;

endmodule

// File: tb/tb_ram_sp_be_init.sv
// Directed bench: three RAM variants share one stimulus stream and are checked against hand-computed values.
module tb_ram_sp_be_init;

  localparam logic [31:0] INIT_C = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, we, clr;
  logic [3:0]  be;
  logic [9:0]  addr;
  logic [31:0] din;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ram_sp_be_init_if #(.DW(32), .AW(10)) ifa ();
  ram_sp_be_init_if #(.DW(32), .AW(10)) ifb ();
  ram_sp_be_init_if #(.DW(32), .AW(10)) ifc ();

  assign ifa.en = en;  assign ifa.we = we;  assign ifa.be = be;
  assign ifa.ADDR = addr;  assign ifa.Din = din;  assign ifa.clr = clr;
  assign ifb.en = en;  assign ifb.we = we;  assign ifb.be = be;
  assign ifb.ADDR = addr;  assign ifb.Din = din;  assign ifb.clr = clr;
  assign ifc.en = en;  assign ifc.we = we;  assign ifc.be = be;
  assign ifc.ADDR = addr;  assign ifc.Din = din;  assign ifc.clr = clr;

  ram_sp_be_init #(.DW(32), .AW(10), .DEPTH(1024), .RD_LAT(1), .WR_MODE(0), .INIT_VAL(32'h0))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  ram_sp_be_init #(.DW(32), .AW(10), .DEPTH(1024), .RD_LAT(2), .WR_MODE(1), .INIT_VAL(32'h0))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  ram_sp_be_init #(.DW(32), .AW(10), .DEPTH(1000), .RD_LAT(1), .WR_MODE(1), .INIT_VAL(INIT_C))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Counts busy cycles per variant over a fixed window; optionally fires writes while busy
  task automatic count_busy(input bit poke, output int ca, output int cb, output int cc,
                            output int hits);
    ca = 0; cb = 0; cc = 0; hits = 0;
    for (int k = 0; k < 1100; k++) begin
      ca += int'(ifa.busy);
      cb += int'(ifb.busy);
      cc += int'(ifc.busy);
      en = poke & ifc.busy; we = 1'b1; be = 4'hF; addr = 10'h020; din = 32'hFFFF_FFFF;
      tick;
      hits += int'(ifa.dvalid) + int'(ifb.dvalid) + int'(ifc.dvalid)
            + int'(ifa.err) + int'(ifb.err) + int'(ifc.err);
    end
    en = 1'b0; we = 1'b0;
  endtask

  initial begin
    int ba, bb, bc, hits;
    int dv_a, dv_b, dv_c, bad;
    logic [9:0]  ra;
    logic [31:0] rd;
    logic [31:0] exp_c;

    rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0; be = 4'h0; addr = '0; din = '0;
    tick; tick;
    chkb("rst_busy_a", ifa.busy, 1'b1);
    chkb("rst_dvalid_a", ifa.dvalid, 1'b0);
    chkb("rst_err_a", ifa.err, 1'b0);
    chk ("rst_dout_a", ifa.Dout, 32'h0);
    chkb("rst_busy_c", ifc.busy, 1'b1);
    rst = 1'b0;

    count_busy(1'b0, ba, bb, bc, hits);
    chk("init_busy_a", ba, 1024);
    chk("init_busy_b", bb, 1024);
    chk("init_busy_c", bc, 1000);
    chk("init_quiet", hits, 0);

    // Reads of 0, 513, 1023 after the power-up clear
    en = 1'b1; we = 1'b0; addr = 10'd0; tick;
    chkb("rd0_dv_a", ifa.dvalid, 1'b1);
    chk ("rd0_a", ifa.Dout, 32'h0);
    chk ("rd0_c", ifc.Dout, INIT_C);
    chkb("rd0_dv_b_early", ifb.dvalid, 1'b0);
    addr = 10'd513; tick;
    chkb("rd513_dv_a", ifa.dvalid, 1'b1);
    chk ("rd513_c", ifc.Dout, INIT_C);
    chkb("rd0_dv_b", ifb.dvalid, 1'b1);
    addr = 10'd1023; tick;
    chk ("rd1023_a", ifa.Dout, 32'h0);
    chkb("rd1023_err_a", ifa.err, 1'b0);
    chkb("rd1023_dv_c", ifc.dvalid, 1'b1);
    chkb("rd1023_err_c", ifc.err, 1'b1);
    chk ("rd1023_c", ifc.Dout, 32'h0);
    en = 1'b0; tick;
    chkb("idle_dv_a", ifa.dvalid, 1'b0);
    chkb("idle_err_c", ifc.err, 1'b0);

    // Byte-lane write 0xDEADBEEF, be=0101, to 0x155
    en = 1'b1; we = 1'b1; be = 4'b0101; addr = 10'h155; din = 32'hDEAD_BEEF; tick;
    chkb("be_wr_dv_a", ifa.dvalid, 1'b0);
    chkb("be_wr_dv_c", ifc.dvalid, 1'b1);
    chk ("be_wr_c", ifc.Dout, 32'h5AAD_C3EF);
    we = 1'b0; tick;
    chkb("be_rd_dv_a", ifa.dvalid, 1'b1);
    chk ("be_rd_a", ifa.Dout, 32'h00AD_00EF);
    chkb("be_wr_dv_b", ifb.dvalid, 1'b1);
    chk ("be_wr_b", ifb.Dout, 32'h00AD_00EF);
    chk ("be_rd_c", ifc.Dout, 32'h5AAD_C3EF);
    en = 1'b0; tick;
    chkb("be_rd_dv_b", ifb.dvalid, 1'b1);
    chk ("be_rd_b", ifb.Dout, 32'h00AD_00EF);
    chkb("be_idle_dv_a", ifa.dvalid, 1'b0);
    chk ("be_hold_a", ifa.Dout, 32'h00AD_00EF);
    tick;
    chkb("be_idle_dv_b", ifb.dvalid, 1'b0);

    // Full-word write to address 7: NO_CHANGE vs WRITE_FIRST
    en = 1'b1; we = 1'b1; be = 4'hF; addr = 10'd7; din = 32'h1234_5678; tick;
    chkb("wm_dv_a", ifa.dvalid, 1'b0);
    chk ("wm_hold_a", ifa.Dout, 32'h00AD_00EF);
    chkb("wm_dv_c", ifc.dvalid, 1'b1);
    chk ("wm_c", ifc.Dout, 32'h1234_5678);
    en = 1'b0; tick;
    chkb("wm_dv_b", ifb.dvalid, 1'b1);
    chk ("wm_b", ifb.Dout, 32'h1234_5678);
    chkb("wm_idle_dv_c", ifc.dvalid, 1'b0);

    // Out-of-range on the 1000-word variant
    en = 1'b1; we = 1'b1; be = 4'hF; addr = 10'd1005; din = 32'hCAFE_F00D; tick;
    chkb("oor_wr_err_c", ifc.err, 1'b1);
    chkb("oor_wr_err_a", ifa.err, 1'b0);
    we = 1'b0; tick;
    chkb("oor_rd_err_c", ifc.err, 1'b1);
    chkb("oor_rd_dv_c", ifc.dvalid, 1'b1);
    chk ("oor_rd_c", ifc.Dout, 32'h0);
    chk ("oor_rd_a", ifa.Dout, 32'hCAFE_F00D);
    addr = 10'd5; tick;
    chk ("alias5_c", ifc.Dout, INIT_C);
    chkb("alias5_err_c", ifc.err, 1'b0);
    addr = 10'd493; tick;
    chk ("alias493_c", ifc.Dout, INIT_C);
    en = 1'b0; tick;

    // Random write/read pairs on consecutive cycles
    dv_a = 0; dv_b = 0; dv_c = 0;
    for (int k = 0; k < 20; k++) begin
      ra = 10'($urandom_range(340, 8));
      rd = $urandom;
      en = 1'b1; we = 1'b1; be = 4'hF; addr = ra; din = rd; tick;
      dv_a += int'(ifa.dvalid); dv_b += int'(ifb.dvalid); dv_c += int'(ifc.dvalid);
      we = 1'b0; tick;
      dv_a += int'(ifa.dvalid); dv_b += int'(ifb.dvalid); dv_c += int'(ifc.dvalid);
      chk("rnd_rd_a", ifa.Dout, rd);
      chk("rnd_rd_c", ifc.Dout, rd);
    end
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick;
      dv_a += int'(ifa.dvalid); dv_b += int'(ifb.dvalid); dv_c += int'(ifc.dvalid);
    end
    chk("rnd_dv_count_a", dv_a, 20);
    chk("rnd_dv_count_b", dv_b, 40);
    chk("rnd_dv_count_c", dv_c, 40);

    // clr during traffic: the earlier read completes, the colliding one is dropped
    en = 1'b1; we = 1'b0; addr = 10'd7; tick;
    chkb("preclr_dv_a", ifa.dvalid, 1'b1);
    chk ("preclr_a", ifa.Dout, 32'h1234_5678);
    clr = 1'b1; tick;
    clr = 1'b0; en = 1'b0;
    chkb("clr_busy_a", ifa.busy, 1'b1);
    chkb("clr_drop_a", ifa.dvalid, 1'b0);
    chkb("preclr_dv_b", ifb.dvalid, 1'b1);
    chk ("preclr_b", ifb.Dout, 32'h1234_5678);
    count_busy(1'b1, ba, bb, bc, hits);
    chk("clr_busy_cnt_a", ba, 1024);
    chk("clr_busy_cnt_b", bb, 1024);
    chk("clr_busy_cnt_c", bc, 1000);
    chk("clr_ignored", hits, 0);
    en = 1'b1; we = 1'b0; addr = 10'd7; tick;
    chk("postclr7_a", ifa.Dout, 32'h0);
    chk("postclr7_c", ifc.Dout, INIT_C);
    addr = 10'h020; tick;
    chk("postclr20_a", ifa.Dout, 32'h0);
    chk("postclr20_c", ifc.Dout, INIT_C);

    // Reset in the middle of a read, then again in the middle of the clear
    we = 1'b1; be = 4'hF; addr = 10'd900; din = 32'h1111_1111; tick;
    addr = 10'd20; din = 32'h2222_2222; tick;
    we = 1'b0; addr = 10'd900; tick;
    chk("prerst_c", ifc.Dout, 32'h1111_1111);
    rst = 1'b1; en = 1'b0; #1;
    chkb("rst_flush_dv_c", ifc.dvalid, 1'b0);
    chk ("rst_flush_c", ifc.Dout, 32'h0);
    tick;
    chkb("rst_flush_dv_b", ifb.dvalid, 1'b0);
    rst = 1'b0;
    repeat (500) tick;
    chkb("midclr_busy_a", ifa.busy, 1'b1);
    rst = 1'b1; tick;
    rst = 1'b0;
    count_busy(1'b0, ba, bb, bc, hits);
    chk("rstclr_busy_a", ba, 1024);
    chk("rstclr_busy_b", bb, 1024);
    chk("rstclr_busy_c", bc, 1000);
    chk("rstclr_quiet", hits, 0);

    bad = 0;
    en = 1'b1; we = 1'b0;
    for (int a = 0; a < 1024; a++) begin
      addr = 10'(a);
      tick;
      exp_c = (a < 1000) ? INIT_C : 32'h0;
      if (ifa.Dout !== 32'h0 || ifa.dvalid !== 1'b1) bad++;
      if (ifc.Dout !== exp_c || ifc.dvalid !== 1'b1) bad++;
    end
    en = 1'b0;
    chk("clear_all_words", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ram_sp_be_init.md
Name: ram_sp_be_init

Overview:
- Parametrised single-port synchronous RAM; next generation of the fixed 1024x32 single-port RAM.
- Adds configurable width and depth, per-byte write enables, configurable read latency, write-mode selection and out-of-range detection.
- Adds a hardware clear engine that fills memory with INIT_VAL after reset or on request.
- Sits between datapath/controller logic and storage; clients must poll busy before issuing accesses.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 10, address width in bits.
- DEPTH, 1024, number of words; DEPTH <= 2**AW.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_MODE, 0, 0 = NO_CHANGE (a write leaves Dout untouched, no dvalid); 1 = WRITE_FIRST (a write returns the merged new word with dvalid).
- INIT_VAL, 0, DW-bit word written to every location by the clear engine.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, access request; sampled only when busy=0.
- we, in, 1, 1 = write, 0 = read; qualified by en.
- be, in, DW/8, byte-lane write enables; be[i] covers Din[8i+7:8i].
- ADDR, in, AW, word address.
- Din, in, DW, write data.
- clr, in, 1, one-cycle pulse requesting a full clear.
- Dout, out, DW, read data; holds its value between dvalid pulses.
- dvalid, out, 1, one-cycle pulse marking Dout valid.
- err, out, 1, one-cycle pulse for an out-of-range access; same latency as dvalid.
- busy, out, 1, high while the clear engine runs.

Behaviour:
- Reset (async, rst=1):
  - Dout=0, dvalid=0, err=0, busy=1.
  - Read pipeline flushed; FSM enters CLEAR with clear counter=0.
  - Memory contents are not reset directly; they are overwritten by the clear engine.
- FSM CLEAR:
  - Each cycle writes INIT_VAL to mem[cnt], then increments cnt.
  - After writing DEPTH-1, the next cycle goes to IDLE and busy falls.
  - busy is high for exactly DEPTH cycles after rst deasserts.
- FSM IDLE:
  - clr=1 enters CLEAR with cnt=0; busy rises on the next edge.
  - If clr and en are high in the same cycle, clr wins and the access is dropped.
  - clr while busy is ignored.
- Accesses while busy=1: ignored (no write, no dvalid, no err). Pipeline entries issued before a clr request still complete.
- Write (en=1, we=1, ADDR<DEPTH):
  - Lanes with be[i]=1 are updated at the edge; other lanes keep their contents.
  - be=0 is a legal no-op write.
  - WR_MODE=1: dvalid pulses RD_LAT cycles later and Dout = merged word.
  - WR_MODE=0: no dvalid, Dout unchanged.
- Read (en=1, we=0, ADDR<DEPTH): Dout = mem[ADDR] and dvalid=1 exactly RD_LAT cycles after the request edge.
- Back-to-back accesses: one access per cycle, fully pipelined; dvalid pulses stay in request order.
- Read of an address written in an earlier cycle returns the new data.
- Out of range (ADDR>=DEPTH):
  - Writes are ignored.
  - Reads return Dout=0 with dvalid=1.
  - err=1 for both reads and writes, aligned with the cycle dvalid would occur.
- Reset mid-clear or mid-read: pipeline flushed, counter restarts at 0, no stale dvalid after rst deasserts.

Test Plan:
- Reset, then hold en=0 -> busy=1 for exactly DEPTH cycles; reads of addresses 0, 513 and 1023 each return INIT_VAL with dvalid.
- Write Din=0xDEADBEEF with be=4'b0101 to 0x155 (prior content 0) -> read returns 0x00AD00EF with dvalid RD_LAT cycles after the request; repeat with RD_LAT=2.
- Issue 20 random write/read pairs with random data and addresses on consecutive cycles -> every read returns the last written data; dvalid count = 20; no gaps.
- With WR_MODE=1, write 0x12345678 to address 7 -> dvalid on the write with Dout=0x12345678. With WR_MODE=0, same write -> no dvalid, Dout holds its prior value.
- DEPTH=1000, AW=10: write to 1005, then read 1005 -> both accesses pulse err; read gives Dout=0; address 1005-1024 aliasing check shows no memory changed.
- Pulse clr mid-traffic -> busy for DEPTH cycles, accesses issued during busy are ignored. Assert rst halfway through the clear -> clear restarts, busy=DEPTH cycles again, all words read back as INIT_VAL.
